// File: rtl/linear_search_pkg.sv
// linear_search_pkg: shared state encoding and default geometry for the linear search controller
package linear_search_pkg;
    typedef enum logic [1:0] {IDLE, SEARCH, DONE} state_t;
    localparam int ADDR_W_DEF = 8;
    localparam int DATA_W_DEF = 3;
    localparam int DEPTH_DEF  = 8;
endpackage

// File: rtl/linear_search_ctrl.sv
// linear_search_ctrl: idle-time table loader and pipelined lowest-address key search over a single-port RAM
module linear_search_ctrl
    import linear_search_pkg::*;
#(
    parameter int ADDR_W = ADDR_W_DEF,
    parameter int DATA_W = DATA_W_DEF,
    parameter int DEPTH  = DEPTH_DEF
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              wr_en,
    input  logic [ADDR_W-1:0] wr_addr,
    input  logic [DATA_W-1:0] wr_data,
    output logic              wr_rdy,
    input  logic              start,
    input  logic [DATA_W-1:0] key,
    output logic              busy,
    output logic              done,
    output logic              found,
    output logic [ADDR_W-1:0] found_addr,
    output logic              mem_ce,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_data,
    input  logic [DATA_W-1:0] mem_q
);
    localparam int IDX_W = $clog2(DEPTH);
    localparam logic [ADDR_W-1:0] LAST = ADDR_W'(DEPTH - 1);
    localparam logic [ADDR_W-1:0] ADDR_MASK = ADDR_W'((64'd1 << IDX_W) - 64'd1);
    state_t state, state_nx;
    logic [DATA_W-1:0] key_q;
    logic [ADDR_W-1:0] issue_addr, cmp_addr;
    logic issue_end, cmp_valid, issued, hit, miss, accept, wr_go;
    assign accept = (state == IDLE) && start;
    assign wr_go  = (state == IDLE) && !start && wr_en;
    assign issued = (state == SEARCH) && !issue_end;
    assign hit    = (state == SEARCH) && cmp_valid && (mem_q == key_q);
    assign miss   = (state == SEARCH) && cmp_valid && (cmp_addr == LAST) && !hit;
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            state <= IDLE;
        else
            state <= state_nx;
    end
    always_comb begin
        state_nx = state;
        case (state)
            IDLE:    state_nx = start ? SEARCH : IDLE;
            SEARCH:  state_nx = (hit || miss) ? DONE : SEARCH;
            default: state_nx = IDLE;
        endcase
    end
    // issue_end freezes the counter at LAST so it can never wrap, even when DEPTH fills the address space
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            key_q      <= '0;
            issue_addr <= '0;
            issue_end  <= 1'b0;
            cmp_addr   <= '0;
            cmp_valid  <= 1'b0;
            found      <= 1'b0;
            found_addr <= '0;
        end else if (accept) begin
            key_q      <= key;
            issue_addr <= '0;
            issue_end  <= 1'b0;
            cmp_valid  <= 1'b0;
            found      <= 1'b0;
            found_addr <= '0;
        end else if (state == SEARCH) begin
            cmp_valid <= issued;
            cmp_addr  <= issue_addr;
            if (issued) begin
                if (issue_addr == LAST)
                    issue_end <= 1'b1;
                else
                    issue_addr <= issue_addr + ADDR_W'(1);
            end
            if (hit) begin
                found      <= 1'b1;
                found_addr <= cmp_addr;
            end else if (miss) begin
                found      <= 1'b0;
                found_addr <= '0;
            end
        end
    end
    // RAM strobes are gated by rst_n so reset silences the RAM without waiting for a clock
    always_comb begin
        wr_rdy   = (state == IDLE) && !start;
        busy     = (state == SEARCH);
        done     = (state == DONE);
        mem_ce   = rst_n && (wr_go || issued);
        mem_we   = rst_n && wr_go;
        mem_addr = (state == IDLE) ? (wr_addr & ADDR_MASK) : issue_addr;
        mem_data = (state == IDLE) ? wr_data : '0;
    end
endmodule

// File: tb/tb_linear_search_ctrl.sv
// tb_linear_search_ctrl: directed bench driving the controller against a behavioural 8x3 RAM
module tb_linear_search_ctrl;
    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       wr_en = 1'b0;
    logic [7:0] wr_addr = '0;
    logic [2:0] wr_data = '0;
    logic       wr_rdy;
    logic       start = 1'b0;
    logic [2:0] key = '0;
    logic       busy, done, found;
    logic [7:0] found_addr;
    logic       mem_ce, mem_we;
    logic [7:0] mem_addr;
    logic [2:0] mem_data, mem_q;
    logic [2:0] mem [8];
    logic [2:0] r_addr = '0;
    int checks = 0;
    int errors = 0;
    int we_cnt = 0;

    linear_search_ctrl dut (
        .clk(clk), .rst_n(rst_n), .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
        .wr_rdy(wr_rdy), .start(start), .key(key), .busy(busy), .done(done), .found(found),
        .found_addr(found_addr), .mem_ce(mem_ce), .mem_we(mem_we), .mem_addr(mem_addr),
        .mem_data(mem_data), .mem_q(mem_q)
    );

    always #5 clk = ~clk;

    // RAM model: registered read address, q follows the held address
    always @(posedge clk) begin
        if (mem_ce) begin
            if (mem_we) mem[mem_addr[2:0]] <= mem_data;
            r_addr <= mem_addr[2:0];
        end
        if (mem_ce && mem_we) we_cnt++;
    end
    assign mem_q = mem[r_addr];

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic write(input logic [7:0] a, input logic [2:0] d);
        @(negedge clk);
        wr_en = 1'b1; wr_addr = a; wr_data = d;
        #1;
        check("wr_pass", {mem_ce, mem_we, mem_addr, 3'b0, mem_data}, {2'b11, a, 3'b0, d});
        @(negedge clk);
        wr_en = 1'b0;
    endtask

    task automatic load(input logic [2:0] t [8]);
        for (int i = 0; i < 8; i++) write(8'(i), t[i]);
    endtask

    task automatic search(input string tag, input logic [2:0] k, input bit wr_too, input bit inject,
                          input bit exp_found, input logic [7:0] exp_addr, input int exp_n);
        int n, busy_cnt, rdy_bad;
        @(negedge clk);
        start = 1'b1; key = k;
        if (wr_too) begin wr_en = 1'b1; wr_addr = 8'd1; wr_data = 3'd0; end
        we_cnt = 0;
        @(posedge clk);
        @(negedge clk);
        start = 1'b0; wr_en = 1'b0; key = ~k;
        n = 0; busy_cnt = 0; rdy_bad = 0;
        while (!done && n < 20) begin
            busy_cnt += busy ? 1 : 0;
            rdy_bad += wr_rdy ? 1 : 0;
            if (inject && n == 1) begin
                start = 1'b1; key = 3'd0; wr_en = 1'b1; wr_addr = 8'd0; wr_data = 3'd6;
            end else if (inject && n == 2) begin
                start = 1'b0; wr_en = 1'b0;
            end
            @(negedge clk);
            n++;
        end
        rdy_bad += wr_rdy ? 1 : 0;
        check({tag, "_lat"}, 32'(n), 32'(exp_n));
        check({tag, "_found"}, {31'b0, found}, {31'b0, exp_found});
        check({tag, "_addr"}, {24'b0, found_addr}, {24'b0, exp_addr});
        check({tag, "_busy"}, 32'(busy_cnt), 32'(exp_n));
        check({tag, "_busy_at_done"}, {31'b0, busy}, 32'd0);
        check({tag, "_wr_rdy"}, 32'(rdy_bad), 32'd0);
        check({tag, "_we"}, 32'(we_cnt), 32'd0);
        @(negedge clk);
        check({tag, "_pulse"}, {31'b0, done}, 32'd0);
        check({tag, "_hold"}, {23'b0, found, found_addr}, {23'b0, exp_found, exp_addr});
    endtask

    initial begin
        logic [2:0] t_main [8] = '{3'd5, 3'd1, 3'd7, 3'd3, 3'd2, 3'd6, 3'd0, 3'd4};
        logic [2:0] t_two  [8] = '{3'd2, 3'd2, 3'd2, 3'd2, 3'd2, 3'd2, 3'd1, 3'd2};
        wr_en = 1'b1;
        repeat (3) @(negedge clk);
        check("rst_outs", {28'b0, busy, done, found, mem_ce}, 32'd0);
        check("rst_we", {31'b0, mem_we}, 32'd0);
        check("rst_addr", {24'b0, found_addr}, 32'd0);
        wr_en = 1'b0;
        rst_n = 1'b1;
        @(negedge clk);
        check("idle_rdy", {31'b0, wr_rdy}, 32'd1);

        load(t_main);
        search("k3", 3'd3, 1'b0, 1'b0, 1'b1, 8'd3, 5);
        search("k5", 3'd5, 1'b0, 1'b0, 1'b1, 8'd0, 2);
        search("k4", 3'd4, 1'b0, 1'b0, 1'b1, 8'd7, 9);

        load(t_two);
        search("k1", 3'd1, 1'b0, 1'b0, 1'b1, 8'd6, 8);
        search("miss", 3'd3, 1'b0, 1'b0, 1'b0, 8'd0, 9);

        load(t_main);
        write(8'd2, 3'd6);
        search("dup", 3'd6, 1'b0, 1'b1, 1'b1, 8'd2, 4);
        check("dup_mem0", {29'b0, mem[0]}, 32'd5);
        search("after_dup", 3'd5, 1'b0, 1'b0, 1'b1, 8'd0, 2);

        search("st_wr", 3'd3, 1'b1, 1'b0, 1'b1, 8'd3, 5);
        check("st_wr_mem1", {29'b0, mem[1]}, 32'd1);

        write(8'd2, 3'd7);
        @(negedge clk);
        start = 1'b1; key = 3'd0;
        @(posedge clk);
        @(negedge clk);
        start = 1'b0;
        check("pre_rst_busy", {31'b0, busy}, 32'd1);
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b0;
        #1;
        check("arst_outs", {28'b0, busy, done, found, mem_ce}, 32'd0);
        check("arst_addr", {23'b0, mem_we, found_addr}, 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        check("arst_idle", {31'b0, wr_rdy}, 32'd1);
        search("post_rst", 3'd7, 1'b0, 1'b0, 1'b1, 8'd2, 4);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
